// File: rtl/key_event_scheduler.sv
// key_event_scheduler: sync, debounce and round-robin arbitration of key events.
// Auto-repeat hardware is built only when KEY_REPEAT_EN is defined.
module key_event_scheduler #(
  parameter int N_KEYS       = 5,
  parameter int TICK_DIV     = 100000,
  parameter int DEB_TICKS    = 20,
  parameter int REPEAT_DELAY = 500,
  parameter int REPEAT_RATE  = 100
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_KEYS-1:0]         key_in,
  output logic [N_KEYS-1:0]         key_level,
  output logic                      evt_valid,
  input  logic                      evt_ready,
  output logic [$clog2(N_KEYS)-1:0] evt_id,
  output logic                      evt_repeat,
  output logic                      evt_ovf
);

  localparam int IDW = $clog2(N_KEYS);
  localparam int TW  = $clog2(TICK_DIV + 1);
  localparam int DW  = $clog2(DEB_TICKS + 1);

  typedef enum logic {IDLE, OFFER} state_t;

  logic [N_KEYS-1:0] sync1_q, sync_q;
  logic [TW-1:0]     tick_cnt_q, tick_cnt_d;
  logic              tick;
  logic [DW-1:0]     db_cnt_q [N_KEYS];
  logic [DW-1:0]     db_cnt_d [N_KEYS];
  logic [N_KEYS-1:0] key_level_q, key_level_d;
  logic [N_KEYS-1:0] prev_q;
  logic [N_KEYS-1:0] press, rep_hit, set_req;
  logic [N_KEYS-1:0] pending_q, pending_d;
  logic [N_KEYS-1:0] grant_clr;
  logic              ovf_q, ovf_d;
  state_t            state_q, state_d;
  logic [IDW-1:0]    ptr_q, ptr_d;
  logic [IDW-1:0]    id_q, id_d;
  logic [IDW-1:0]    sel;
  logic              found, grant;

  always_comb begin
    tick       = (tick_cnt_q == TW'(TICK_DIV - 1));
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
  end

  // A level is accepted only after DEB_TICKS consecutive mismatching ticks.
  always_comb begin
    key_level_d = key_level_q;
    for (int i = 0; i < N_KEYS; i++) begin
      db_cnt_d[i] = db_cnt_q[i];
      if (sync_q[i] == key_level_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (tick) begin
        if (db_cnt_q[i] == DW'(DEB_TICKS - 1)) begin
          key_level_d[i] = sync_q[i];
          db_cnt_d[i]    = '0;
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign press = key_level_q & ~prev_q;

  always_comb begin : arb_search
    int j;
    found = 1'b0;
    sel   = '0;
    for (int k = 0; k < N_KEYS; k++) begin
      j = int'(ptr_q) + k;
      if (j >= N_KEYS) j = j - N_KEYS;
      if (!found && pending_q[j]) begin
        found = 1'b1;
        sel   = IDW'(j);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    ptr_d     = ptr_q;
    grant_clr = '0;
    grant     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          grant          = 1'b1;
          grant_clr[sel] = 1'b1;
          id_d           = sel;
          state_d        = OFFER;
        end
      end
      OFFER: begin
        if (evt_ready) begin
          ptr_d   = (id_q == IDW'(N_KEYS - 1)) ? '0 : id_q + 1'b1;
          state_d = IDLE;
        end
      end
    endcase
  end

  // New requests override a same-cycle grant clear.
  always_comb begin
    set_req   = press | rep_hit;
    pending_d = (pending_q & ~grant_clr) | set_req;
    ovf_d     = |(set_req & pending_q & ~grant_clr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q     <= '0;
      sync_q      <= '0;
      tick_cnt_q  <= '0;
      key_level_q <= '0;
      prev_q      <= '0;
      pending_q   <= '0;
      ovf_q       <= 1'b0;
      state_q     <= IDLE;
      ptr_q       <= '0;
      id_q        <= '0;
      for (int i = 0; i < N_KEYS; i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q     <= key_in;
      sync_q      <= sync1_q;
      tick_cnt_q  <= tick_cnt_d;
      key_level_q <= key_level_d;
      prev_q      <= key_level_q;
      pending_q   <= pending_d;
      ovf_q       <= ovf_d;
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      for (int i = 0; i < N_KEYS; i++) db_cnt_q[i] <= db_cnt_d[i];
    end
  end

`ifdef KEY_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX + 1);

  logic [RW-1:0]     rep_cnt_q [N_KEYS];
  logic [RW-1:0]     rep_cnt_d [N_KEYS];
  logic [N_KEYS-1:0] rep_ph_q, rep_ph_d;
  logic [N_KEYS-1:0] pend_rep_q, pend_rep_d;
  logic              rep_q, rep_d;

  // rep_ph marks that the initial delay is over and the rate period applies.
  always_comb begin
    rep_hit  = '0;
    rep_ph_d = rep_ph_q;
    for (int i = 0; i < N_KEYS; i++) begin
      rep_cnt_d[i] = rep_cnt_q[i];
      if (!key_level_q[i]) begin
        rep_cnt_d[i] = '0;
        rep_ph_d[i]  = 1'b0;
      end else if (tick) begin
        if (rep_cnt_q[i] == (rep_ph_q[i] ? RW'(REPEAT_RATE - 1)
                                         : RW'(REPEAT_DELAY - 1))) begin
          rep_hit[i]   = 1'b1;
          rep_cnt_d[i] = '0;
          rep_ph_d[i]  = 1'b1;
        end else begin
          rep_cnt_d[i] = rep_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    pend_rep_d = pend_rep_q;
    for (int i = 0; i < N_KEYS; i++) begin
      if (press[i])
        pend_rep_d[i] = 1'b0;
      else if (rep_hit[i] && !(pending_q[i] && !grant_clr[i]))
        pend_rep_d[i] = 1'b1;
    end
    rep_d = grant ? pend_rep_q[sel] : rep_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_ph_q   <= '0;
      pend_rep_q <= '0;
      rep_q      <= 1'b0;
      for (int i = 0; i < N_KEYS; i++) rep_cnt_q[i] <= '0;
    end else begin
      rep_ph_q   <= rep_ph_d;
      pend_rep_q <= pend_rep_d;
      rep_q      <= rep_d;
      for (int i = 0; i < N_KEYS; i++) rep_cnt_q[i] <= rep_cnt_d[i];
    end
  end

  assign evt_repeat = rep_q;
`else
  assign rep_hit    = '0;
  assign evt_repeat = 1'b0;
`endif

  assign key_level = key_level_q;
  assign evt_valid = (state_q == OFFER);
  assign evt_id    = id_q;
  assign evt_ovf   = ovf_q;

endmodule

// File: tb/tb_key_event_scheduler.sv
// tb_key_event_scheduler: scenario tasks with randomized key masks
// checked against a round-robin reference model.
module tb_key_event_scheduler;

  localparam int N   = 5;
  localparam int TD  = 4;
  localparam int DEB = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] key_in = '0;
  logic [N-1:0] key_level;
  logic         evt_valid;
  logic         evt_ready = 1'b0;
  logic [2:0]   evt_id;
  logic         evt_repeat;
  logic         evt_ovf;

  key_event_scheduler #(
    .N_KEYS(N), .TICK_DIV(TD), .DEB_TICKS(DEB),
    .REPEAT_DELAY(6), .REPEAT_RATE(2)
  ) dut (
    .clk(clk), .rst(rst), .key_in(key_in), .key_level(key_level),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_id(evt_id),
    .evt_repeat(evt_repeat), .evt_ovf(evt_ovf)
  );

  always #5 clk = ~clk;

  typedef struct { int id; logic rep; int c; } ev_t;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   rel_cyc = 0;
  int   ovf_cnt = 0;
  int   ptr_m = 0;
  bit   pv = 1'b0;
  ev_t  evq[$];
  int   vrise[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst) begin
      pv = 1'b0;
    end else begin
      if (evt_valid && !pv) vrise.push_back(cyc);
      pv = evt_valid;
      if (evt_valid && evt_ready)
        evq.push_back('{id: int'(evt_id), rep: evt_repeat, c: cyc});
      if (evt_ovf) ovf_cnt++;
    end
  end

  function automatic bit is_tick(int c);
    return ((c - rel_cyc) % TD) == TD - 1;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    key_in = '0;
    evt_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    rel_cyc = cyc;
    evq.delete();
    vrise.delete();
    ovf_cnt = 0;
    ptr_m = 0;
  endtask

  task automatic wait_lvl(input logic [N-1:0] m, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (key_level == m) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    total++;
    if (key_level !== '0) begin
      bad++; $display("FAIL reset_level got=%0h want=0", key_level);
    end
    total++;
    if (evt_valid !== 1'b0) begin
      bad++; $display("FAIL reset_valid got=%0b want=0", evt_valid);
    end
    total++;
    if (evt_id !== 3'd0) begin
      bad++; $display("FAIL reset_id got=%0d want=0", evt_id);
    end
    total++;
    if (evt_repeat !== 1'b0) begin
      bad++; $display("FAIL reset_repeat got=%0b want=0", evt_repeat);
    end
    total++;
    if (evt_ovf !== 1'b0) begin
      bad++; $display("FAIL reset_ovf got=%0b want=0", evt_ovf);
    end
  endtask

  task automatic test_clean_press();
    int c0, t, tk, tr;
    @(posedge clk);
    #1;
    evt_ready = 1'b1;
    key_in[2] = 1'b1;
    c0 = cyc;
    tk = 0;
    t = c0 + 2;
    forever begin
      if (is_tick(t)) begin
        tk++;
        if (tk == DEB) break;
      end
      t++;
    end
    tr = t + 1;
    for (int n = 0; n < 200 && cyc < tr - 1; n++) @(negedge clk);
    total++;
    if (cyc != tr - 1 || key_level[2] !== 1'b0) begin
      bad++; $display("FAIL clean_early lvl=%0b cyc=%0d want 0 at %0d",
                      key_level[2], cyc, tr - 1);
    end
    @(negedge clk);
    total++;
    if (key_level[2] !== 1'b1) begin
      bad++; $display("FAIL clean_level got=%0b want=1", key_level[2]);
    end
    key_in[2] = 1'b0;
    repeat (40) @(negedge clk);
    total++;
    if (vrise.size() != 1 || vrise[0] != tr + 2) begin
      bad++; $display("FAIL clean_valid_time n=%0d at=%0d want at %0d",
                      vrise.size(), (vrise.size() > 0) ? vrise[0] : -1, tr + 2);
    end
    total++;
    if (evq.size() != 1) begin
      bad++; $display("FAIL clean_count got=%0d want=1", evq.size());
    end
    total++;
    if (evq.size() < 1 || evq[0].id != 2 || evq[0].rep !== 1'b0) begin
      bad++; $display("FAIL clean_event got id=%0d rep=%0b want id=2 rep=0",
                      (evq.size() > 0) ? evq[0].id : -1,
                      (evq.size() > 0) ? evq[0].rep : 1'bx);
    end
    ptr_m = 3;
  endtask

  task automatic test_bounce();
    logic seen;
    seen = 1'b0;
    evq.delete();
    for (int n = 0; n < 90; n++) begin
      @(posedge clk);
      #1;
      if (n < 60 && n % 5 == 0) key_in[1] = ~key_in[1];
      seen |= key_level[1];
    end
    total++;
    if (seen !== 1'b0) begin
      bad++; $display("FAIL bounce_level got=%0b want=0", seen);
    end
    total++;
    if (evq.size() != 0) begin
      bad++; $display("FAIL bounce_events got=%0d want=0", evq.size());
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] mask;
    int exp_ids[$];
    bit ok;
    do_reset();
    evt_ready = 1'b1;
    for (int r = 0; r < 6; r++) begin
      mask = (r < 2) ? 5'b11001 : N'($urandom_range(1, (1 << N) - 1));
      exp_ids.delete();
      for (int k = 0; k < N; k++)
        if (mask[(ptr_m + k) % N]) exp_ids.push_back((ptr_m + k) % N);
      ptr_m = (exp_ids[exp_ids.size() - 1] + 1) % N;
      evq.delete();
      @(posedge clk);
      #1 key_in = mask;
      wait_lvl(mask, ok);
      total++;
      if (!ok) begin
        bad++; $display("FAIL rr_timeout got=%0h want=%0h", key_level, mask);
      end
      key_in = '0;
      wait_lvl('0, ok);
      repeat (10) @(negedge clk);
      total++;
      if (evq.size() != exp_ids.size()) begin
        bad++; $display("FAIL rr_count mask=%0h got=%0d want=%0d",
                        mask, evq.size(), exp_ids.size());
      end
      for (int i = 0; i < exp_ids.size() && i < evq.size(); i++) begin
        total++;
        if (evq[i].id != exp_ids[i]) begin
          bad++; $display("FAIL rr_id mask=%0h idx=%0d got=%0d want=%0d",
                          mask, i, evq[i].id, exp_ids[i]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    evt_ready = 1'b0;
    ovf_cnt = 0;
    evq.delete();
    repeat (3) begin
      @(posedge clk);
      #1 key_in[1] = 1'b1;
      wait_lvl(5'b00010, ok);
      key_in[1] = 1'b0;
      wait_lvl('0, ok);
    end
    repeat (5) @(negedge clk);
    total++;
    if (evt_valid !== 1'b1 || evt_id !== 3'd1) begin
      bad++; $display("FAIL bp_held valid=%0b id=%0d want 1/1", evt_valid, evt_id);
    end
    total++;
    if (evq.size() != 0) begin
      bad++; $display("FAIL bp_stall got=%0d want=0", evq.size());
    end
    total++;
    if (ovf_cnt != 1) begin
      bad++; $display("FAIL bp_ovf got=%0d want=1", ovf_cnt);
    end
    @(posedge clk);
    #1 evt_ready = 1'b1;
    repeat (20) @(negedge clk);
    total++;
    if (evq.size() != 2 || evq[0].id != 1 || evq[1].id != 1) begin
      bad++; $display("FAIL bp_drain got n=%0d want 2 events id=1", evq.size());
    end
    ptr_m = 2;
  endtask

  task automatic test_reset_mid();
    bit ok;
    evt_ready = 1'b0;
    evq.delete();
    @(posedge clk);
    #1 key_in = 5'b01100;
    wait_lvl(5'b01100, ok);
    repeat (4) @(negedge clk);
    total++;
    if (evt_valid !== 1'b1) begin
      bad++; $display("FAIL rstmid_pre got=%0b want=1", evt_valid);
    end
    #2;
    rst = 1'b1;
    key_in = '0;
    #1;
    total++;
    if (evt_valid !== 1'b0 || key_level !== '0) begin
      bad++; $display("FAIL rstmid_async valid=%0b lvl=%0h want 0/0",
                      evt_valid, key_level);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    rel_cyc = cyc;
    evt_ready = 1'b1;
    evq.delete();
    ptr_m = 0;
    repeat (40) @(negedge clk);
    total++;
    if (evq.size() != 0 || evt_valid !== 1'b0) begin
      bad++; $display("FAIL rstmid_quiet got=%0d valid=%0b want 0/0",
                      evq.size(), evt_valid);
    end
  endtask

  task automatic test_repeat();
    int tk, n_exp;
    bit ok;
    ev_t got[$];
`ifdef KEY_REPEAT_EN
    n_exp = 6;
`else
    n_exp = 1;
`endif
    evt_ready = 1'b1;
    evq.delete();
    @(posedge clk);
    #1 key_in[0] = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (key_level[0]) begin
        ok = 1'b1;
        break;
      end
    end
    total++;
    if (!ok) begin
      bad++; $display("FAIL rep_timeout got=%0b want=1", key_level[0]);
    end
    tk = is_tick(cyc) ? 1 : 0;
    while (tk < 14) begin
      @(negedge clk);
      if (is_tick(cyc)) tk++;
    end
    repeat (3) @(negedge clk);
    got = evq;
    key_in[0] = 1'b0;
    total++;
    if (got.size() != n_exp) begin
      bad++; $display("FAIL rep_count got=%0d want=%0d", got.size(), n_exp);
    end
    for (int i = 0; i < got.size() && i < n_exp; i++) begin
      total++;
      if (got[i].id != 0 || got[i].rep !== (i > 0)) begin
        bad++; $display("FAIL rep_event idx=%0d got id=%0d rep=%0b want id=0 rep=%0b",
                        i, got[i].id, got[i].rep, (i > 0));
      end
    end
    repeat (60) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_repeat();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
